// File: rtl/sdram_multiport_front.sv
// Multi-channel SRAM-like front end for the DDR3 controller UI port.
// NUM_CH request channels take turns round-robin on the single controller
// port. Each channel's ready flag only moves on the slow-logic clock-enable
// strobe, so slow masters see a clean four-phase handshake.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no transaction; pick the next pending channel, if any
// ISSUE  | first cycle of sd_cs for the granted channel
// WAIT   | sd_* held, waiting for sd_ready from the controller
// DRAIN  | one cycle with sd_cs low so the controller sees the release
module sdram_multiport_front #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int EXTRA_W = 48,
  localparam int BE_W   = DATA_W / 8,
  localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        i_rst,
  input  logic                        i_rtl_ce,
  input  logic [NUM_CH*ADDR_W-1:0]    ch_addr,
  input  logic [NUM_CH-1:0]           ch_cs,
  input  logic [NUM_CH-1:0]           ch_we,
  input  logic [NUM_CH*BE_W-1:0]      ch_be,
  input  logic [NUM_CH*DATA_W-1:0]    ch_wr,
  input  logic [NUM_CH-1:0]           ch_big_r,
  output logic [NUM_CH*DATA_W-1:0]    ch_rd,
  output logic [NUM_CH*EXTRA_W-1:0]   ch_rd_x,
  output logic [NUM_CH-1:0]           ch_ready,
  output logic [ADDR_W-1:0]           sd_addr,
  output logic                        sd_cs,
  output logic [BE_W-1:0]             sd_be,
  output logic                        sd_we,
  output logic [DATA_W-1:0]           sd_wr,
  output logic                        sd_big_r,
  input  logic [DATA_W-1:0]           sd_rd,
  input  logic [EXTRA_W-1:0]          sd_rd_x,
  input  logic                        sd_ready,
  output logic                        o_busy,
  output logic [GW-1:0]               o_grant
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t                      r_state;
  logic [GW-1:0]               r_rr;
  logic [GW-1:0]               r_grant;
  logic [NUM_CH-1:0]           r_done;
  logic [NUM_CH-1:0]           r_ready;
  logic [NUM_CH*DATA_W-1:0]    r_rd;
  logic [NUM_CH*EXTRA_W-1:0]   r_rd_x;
  logic [ADDR_W-1:0]           r_sd_addr;
  logic                        r_sd_cs;
  logic [BE_W-1:0]             r_sd_be;
  logic                        r_sd_we;
  logic [DATA_W-1:0]           r_sd_wr;
  logic                        r_sd_big_r;

  logic [NUM_CH-1:0]           w_pending;
  logic                        w_any;
  logic [GW-1:0]               w_gidx;

  // Round-robin pick: first pending channel strictly after the last one served.
  always_comb begin : rr_pick
    logic [GW-1:0] idx;
    logic          found;
    w_pending = ch_cs & ~r_done & ~r_ready;
    w_any     = |w_pending;
    w_gidx    = '0;
    found     = 1'b0;
    idx       = r_rr;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (idx == GW'(NUM_CH - 1)) ? '0 : idx + 1'b1;
      if (!found && w_pending[idx]) begin
        found  = 1'b1;
        w_gidx = idx;
      end
    end
  end

  // Sequencer, controller-port registers and slow-strobe ready publication.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_rr       <= GW'(NUM_CH - 1);
      r_grant    <= '0;
      r_done     <= '0;
      r_ready    <= '0;
      r_rd       <= '0;
      r_rd_x     <= '0;
      r_sd_addr  <= '0;
      r_sd_cs    <= 1'b0;
      r_sd_be    <= '0;
      r_sd_we    <= 1'b0;
      r_sd_wr    <= '0;
      r_sd_big_r <= 1'b0;
    end else begin
      // A done flag set on this same edge is published at the next strobe,
      // because the loop below still sees the old done value.
      if (i_rtl_ce) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_done[i]) begin
            r_ready[i] <= 1'b1;
            r_done[i]  <= 1'b0;
          end else if (r_ready[i] && !ch_cs[i]) begin
            r_ready[i] <= 1'b0;
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sd_addr  <= ch_addr[w_gidx*ADDR_W +: ADDR_W];
            r_sd_be    <= ch_be[w_gidx*BE_W +: BE_W];
            r_sd_we    <= ch_we[w_gidx];
            r_sd_wr    <= ch_wr[w_gidx*DATA_W +: DATA_W];
            r_sd_big_r <= ch_big_r[w_gidx];
            r_sd_cs    <= 1'b1;
            r_rr       <= w_gidx;
            r_grant    <= w_gidx;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (sd_ready) begin
            if (!r_sd_we) begin
              r_rd[r_grant*DATA_W +: DATA_W]     <= sd_rd;
              r_rd_x[r_grant*EXTRA_W +: EXTRA_W] <= sd_rd_x;
            end
            // Granted channel was not done, so this never races the clear above.
            r_done[r_grant] <= 1'b1;
            r_sd_cs         <= 1'b0;
            r_state         <= S_DRAIN;
          end
        end
        S_DRAIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_rd    = r_rd;
  assign ch_rd_x  = r_rd_x;
  assign ch_ready = r_ready;
  assign sd_addr  = r_sd_addr;
  assign sd_cs    = r_sd_cs;
  assign sd_be    = r_sd_be;
  assign sd_we    = r_sd_we;
  assign sd_wr    = r_sd_wr;
  assign sd_big_r = r_sd_big_r;
  assign o_busy   = (r_state != S_IDLE);
  assign o_grant  = r_grant;

endmodule

// File: tb/tb_sdram_multiport_front.sv
// Directed bench for sdram_multiport_front: a behavioural controller model,
// a slow-clock strobe every 4 UI cycles and one task per scenario.
module tb_sdram_multiport_front;
  localparam int NC = 3;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int XW = 48;
  localparam int BW = 2;
  localparam int GW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             i_rst = 1'b1;
  logic             i_rtl_ce = 1'b0;
  logic [NC*AW-1:0] ch_addr = '0;
  logic [NC-1:0]    ch_cs = '0;
  logic [NC-1:0]    ch_we = '0;
  logic [NC*BW-1:0] ch_be = '0;
  logic [NC*DW-1:0] ch_wr = '0;
  logic [NC-1:0]    ch_big_r = '0;
  logic [NC*DW-1:0] ch_rd;
  logic [NC*XW-1:0] ch_rd_x;
  logic [NC-1:0]    ch_ready;
  logic [AW-1:0]    sd_addr;
  logic             sd_cs;
  logic [BW-1:0]    sd_be;
  logic             sd_we;
  logic [DW-1:0]    sd_wr;
  logic             sd_big_r;
  logic [DW-1:0]    sd_rd = '0;
  logic [XW-1:0]    sd_rd_x = '0;
  logic             sd_ready = 1'b0;
  logic             o_busy;
  logic [GW-1:0]    o_grant;

  sdram_multiport_front #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .EXTRA_W(XW)) dut (
    .clk(clk), .i_rst(i_rst), .i_rtl_ce(i_rtl_ce),
    .ch_addr(ch_addr), .ch_cs(ch_cs), .ch_we(ch_we), .ch_be(ch_be), .ch_wr(ch_wr),
    .ch_big_r(ch_big_r), .ch_rd(ch_rd), .ch_rd_x(ch_rd_x), .ch_ready(ch_ready),
    .sd_addr(sd_addr), .sd_cs(sd_cs), .sd_be(sd_be), .sd_we(sd_we), .sd_wr(sd_wr),
    .sd_big_r(sd_big_r), .sd_rd(sd_rd), .sd_rd_x(sd_rd_x), .sd_ready(sd_ready),
    .o_busy(o_busy), .o_grant(o_grant)
  );

  int total = 0;
  int bad = 0;

  // controller model knobs, written by the tests only
  logic        ctl_en = 1'b0;
  int          ctl_lat = 4;
  logic [15:0] ctl_rd = '0;
  logic [47:0] ctl_rdx = '0;
  int          kick_req = 0;

  // model state
  int          kick_ack = 0;
  int          ctl_cnt = 0;
  int          ce_cnt = 0;
  int          cs_hi_total = 0;
  int          bad_chg = 0;
  logic [NC-1:0] last_ready = '0;
  logic        pe_ce = 1'b0;
  logic        pe_rst = 1'b0;
  logic        armed = 1'b0;

  int ord [0:3];
  int nord;

  // What the last active edge sampled, for the ready-movement monitor.
  always @(posedge clk) begin
    pe_ce  = i_rtl_ce;
    pe_rst = i_rst;
    if (i_rst) armed = 1'b1;
  end

  // Monitor, slow-clock strobe generator and controller model.
  always @(negedge clk) begin
    if (sd_cs === 1'b1) cs_hi_total++;
    if (armed && !pe_rst && !pe_ce && (ch_ready !== last_ready)) bad_chg++;
    last_ready = ch_ready;
    ce_cnt   = (ce_cnt + 1) % 4;
    i_rtl_ce = (ce_cnt == 0);
    if (sd_ready) begin
      sd_ready = 1'b0;
    end else if (kick_req != kick_ack) begin
      kick_ack = kick_req;
      sd_ready = 1'b1; sd_rd = ctl_rd; sd_rd_x = ctl_rdx; ctl_cnt = 0;
    end else if (ctl_en && sd_cs === 1'b1) begin
      if (ctl_cnt == ctl_lat) begin
        sd_ready = 1'b1; sd_rd = ctl_rd; sd_rd_x = ctl_rdx; ctl_cnt = 0;
      end else begin
        ctl_cnt++;
      end
    end else begin
      ctl_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_ch(input int c, input logic [31:0] a, input logic we,
                        input logic [1:0] be, input logic [15:0] wr, input logic big);
    ch_addr[c*AW +: AW] = a;
    ch_we[c[1:0]]       = we;
    ch_be[c*BW +: BW]   = be;
    ch_wr[c*DW +: DW]   = wr;
    ch_big_r[c[1:0]]    = big;
  endtask

  task automatic wait_rdy(input int c, input logic v, input int lim, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < lim; n++) begin
      if (!ok) begin
        if (ch_ready[c[1:0]] === v) ok = 1'b1;
        else step();
      end
    end
  endtask

  task automatic wait_cs(input int lim, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < lim; n++) begin
      if (!ok) begin
        if (sd_cs === 1'b1) ok = 1'b1;
        else step();
      end
    end
  endtask

  task automatic run_round(input logic [NC-1:0] req, output logic fin);
    logic prev;
    nord = 0; fin = 1'b0; prev = sd_cs;
    ch_cs = req;
    for (int n = 0; n < 400; n++) begin
      if (!fin) begin
        step();
        if (sd_cs && !prev) begin
          if (nord < 4) ord[nord] = int'(o_grant);
          nord++;
        end
        prev = sd_cs;
        for (int c = 0; c < NC; c++)
          if (ch_cs[c] && ch_ready[c]) ch_cs[c] = 1'b0;
        fin = (ch_cs == '0) && (ch_ready == '0) && !o_busy;
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; ch_cs = '0;
    step(); step();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", o_busy); end
    total++; if (sd_cs !== 1'b0) begin bad++; $display("FAIL reset_sd_cs got=%0h exp=0", sd_cs); end
    total++; if (ch_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%0h exp=0", ch_ready); end
    total++; if (ch_rd !== '0 || ch_rd_x !== '0) begin bad++; $display("FAIL reset_rd got=%0h/%0h exp=0", ch_rd, ch_rd_x); end
    total++; if (o_grant !== 2'd0 || sd_addr !== 32'd0 || sd_we !== 1'b0) begin bad++; $display("FAIL reset_regs grant=%0h addr=%0h we=%0h exp=0", o_grant, sd_addr, sd_we); end
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    logic ok; int cs0;
    ctl_en = 1'b1; ctl_lat = 6; ctl_rd = 16'hBEEF; ctl_rdx = 48'h0;
    set_ch(1, 32'h100, 1'b0, 2'b11, 16'h0, 1'b0);
    cs0 = cs_hi_total;
    ch_cs[1] = 1'b1;
    step();
    total++; if (sd_cs !== 1'b1 || sd_addr !== 32'h100 || o_grant !== 2'd1) begin bad++; $display("FAIL rd_issue cs=%0h addr=%0h grant=%0h exp 1/100/1", sd_cs, sd_addr, o_grant); end
    total++; if (o_busy !== 1'b1 || sd_we !== 1'b0) begin bad++; $display("FAIL rd_busy busy=%0h we=%0h exp 1/0", o_busy, sd_we); end
    set_ch(1, 32'h999, 1'b1, 2'b00, 16'h1111, 1'b1);
    step();
    total++; if (sd_addr !== 32'h100 || sd_we !== 1'b0) begin bad++; $display("FAIL rd_hold addr=%0h we=%0h exp 100/0", sd_addr, sd_we); end
    set_ch(1, 32'h100, 1'b0, 2'b11, 16'h0, 1'b0);
    wait_rdy(1, 1'b1, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL rd_ready_rise timeout got=0 exp=1"); end
    total++; if (ch_rd[DW +: DW] !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%0h exp=beef", ch_rd[DW +: DW]); end
    total++; if (cs_hi_total - cs0 !== 7) begin bad++; $display("FAIL rd_cs_len got=%0d exp=7", cs_hi_total - cs0); end
    repeat (6) step();
    total++; if (ch_ready[1] !== 1'b1 || sd_cs !== 1'b0) begin bad++; $display("FAIL rd_ready_hold ready=%0h cs=%0h exp 1/0", ch_ready[1], sd_cs); end
    ch_cs[1] = 1'b0;
    wait_rdy(1, 1'b0, 8, ok);
    total++; if (!ok) begin bad++; $display("FAIL rd_ready_clear timeout got=1 exp=0"); end
  endtask

  task automatic test_big_read();
    logic ok;
    ctl_lat = 3; ctl_rd = 16'h1234; ctl_rdx = 48'hAABBCCDDEEFF;
    set_ch(0, 32'h40, 1'b0, 2'b11, 16'h0, 1'b1);
    ch_cs[0] = 1'b1;
    step();
    total++; if (sd_big_r !== 1'b1 || o_grant !== 2'd0 || sd_addr !== 32'h40) begin bad++; $display("FAIL big_issue big=%0h grant=%0h addr=%0h exp 1/0/40", sd_big_r, o_grant, sd_addr); end
    wait_rdy(0, 1'b1, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL big_ready timeout got=0 exp=1"); end
    total++; if (ch_rd[0 +: DW] !== 16'h1234) begin bad++; $display("FAIL big_rd got=%0h exp=1234", ch_rd[0 +: DW]); end
    total++; if (ch_rd_x[0 +: XW] !== 48'hAABBCCDDEEFF) begin bad++; $display("FAIL big_rd_x got=%0h exp=aabbccddeeff", ch_rd_x[0 +: XW]); end
    total++; if (ch_rd[DW +: DW] !== 16'hBEEF) begin bad++; $display("FAIL big_other_ch got=%0h exp=beef", ch_rd[DW +: DW]); end
    ch_cs[0] = 1'b0; ch_big_r[0] = 1'b0;
    wait_rdy(0, 1'b0, 8, ok);
  endtask

  task automatic test_write();
    logic ok;
    ctl_lat = 2; ctl_rd = 16'hFFFF; ctl_rdx = '1;
    set_ch(2, 32'h200, 1'b1, 2'b10, 16'h5A00, 1'b0);
    ch_cs[2] = 1'b1;
    step();
    total++; if (sd_we !== 1'b1 || sd_be !== 2'b10 || sd_wr !== 16'h5A00 || o_grant !== 2'd2) begin bad++; $display("FAIL wr_issue we=%0h be=%0h wr=%0h grant=%0h exp 1/2/5a00/2", sd_we, sd_be, sd_wr, o_grant); end
    wait_rdy(2, 1'b1, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_ready timeout got=0 exp=1"); end
    total++; if (ch_rd[2*DW +: DW] !== 16'h0 || ch_rd_x[2*XW +: XW] !== 48'h0) begin bad++; $display("FAIL wr_rd_kept got=%0h/%0h exp=0", ch_rd[2*DW +: DW], ch_rd_x[2*XW +: XW]); end
    ch_cs[2] = 1'b0; ch_we[2] = 1'b0;
    wait_rdy(2, 1'b0, 8, ok);
  endtask

  task automatic test_contention();
    logic fin;
    i_rst = 1'b1; step(); i_rst = 1'b0;
    ctl_en = 1'b1; ctl_lat = 2; ctl_rd = 16'h0A0A; ctl_rdx = 48'h0;
    for (int c = 0; c < NC; c++) set_ch(c, 32'h1000 + c, 1'b0, 2'b11, 16'h0, 1'b0);
    run_round(3'b111, fin);
    total++; if (!fin || nord !== 3) begin bad++; $display("FAIL arb3_count fin=%0d got=%0d exp=3", fin, nord); end
    total++; if (ord[0] !== 0 || ord[1] !== 1 || ord[2] !== 2) begin bad++; $display("FAIL arb3_order got=%0d,%0d,%0d exp=0,1,2", ord[0], ord[1], ord[2]); end
    run_round(3'b101, fin);
    total++; if (!fin || nord !== 2) begin bad++; $display("FAIL arb2_count fin=%0d got=%0d exp=2", fin, nord); end
    total++; if (ord[0] !== 0 || ord[1] !== 2) begin bad++; $display("FAIL arb2_order got=%0d,%0d exp=0,2", ord[0], ord[1]); end
  endtask

  task automatic test_ready_alignment();
    logic ok; int n;
    ctl_en = 1'b0; ctl_rd = 16'hC0DE; ctl_rdx = 48'h0;
    set_ch(1, 32'h300, 1'b0, 2'b11, 16'h0, 1'b0);
    ch_cs[1] = 1'b1;
    wait_cs(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL align_grant timeout got=0 exp=1"); end
    repeat (3) step();
    n = 0;
    while (i_rtl_ce !== 1'b1 && n < 8) begin step(); n++; end
    kick_req++;
    step();
    total++; if (ch_ready[1] !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL align_c1 ready=%0h busy=%0h exp 0/1", ch_ready[1], o_busy); end
    step();
    total++; if (ch_ready[1] !== 1'b0) begin bad++; $display("FAIL align_c2 got=%0h exp=0", ch_ready[1]); end
    step();
    total++; if (ch_ready[1] !== 1'b0) begin bad++; $display("FAIL align_c3 got=%0h exp=0", ch_ready[1]); end
    step();
    total++; if (ch_ready[1] !== 1'b1) begin bad++; $display("FAIL align_c4 got=%0h exp=1", ch_ready[1]); end
    total++; if (ch_rd[DW +: DW] !== 16'hC0DE) begin bad++; $display("FAIL align_data got=%0h exp=c0de", ch_rd[DW +: DW]); end
    ch_cs[1] = 1'b0;
    wait_rdy(1, 1'b0, 8, ok);
  endtask

  task automatic test_cs_drop();
    logic ok;
    ctl_en = 1'b0; ctl_rd = 16'h7777;
    set_ch(2, 32'h500, 1'b0, 2'b11, 16'h0, 1'b0);
    ch_cs[2] = 1'b1;
    wait_cs(20, ok);
    step(); step();
    ch_cs[2] = 1'b0;
    step();
    kick_req++;
    wait_rdy(2, 1'b1, 12, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_ready_pulse timeout got=0 exp=1"); end
    total++; if (ch_rd[2*DW +: DW] !== 16'h7777) begin bad++; $display("FAIL drop_data got=%0h exp=7777", ch_rd[2*DW +: DW]); end
    wait_rdy(2, 1'b0, 6, ok);
    total++; if (!ok || o_busy !== 1'b0) begin bad++; $display("FAIL drop_ready_clear ok=%0d busy=%0h exp 1/0", ok, o_busy); end
  endtask

  task automatic test_reset_wait();
    logic ok;
    ctl_en = 1'b0; ctl_rd = 16'h5555; ctl_rdx = 48'h1;
    set_ch(0, 32'h400, 1'b0, 2'b11, 16'h0, 1'b0);
    ch_cs[0] = 1'b1;
    wait_cs(20, ok);
    step(); step();
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL rstw_busy got=%0h exp=1", o_busy); end
    i_rst = 1'b1; ch_cs = '0;
    step();
    i_rst = 1'b0;
    total++; if (sd_cs !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL rstw_idle cs=%0h busy=%0h exp 0/0", sd_cs, o_busy); end
    total++; if (ch_ready !== 3'b000 || o_grant !== 2'd0) begin bad++; $display("FAIL rstw_ready ready=%0h grant=%0h exp 0/0", ch_ready, o_grant); end
    kick_req++;
    repeat (8) step();
    total++; if (o_busy !== 1'b0 || sd_cs !== 1'b0 || ch_ready !== 3'b000) begin bad++; $display("FAIL rstw_late busy=%0h cs=%0h ready=%0h exp 0/0/0", o_busy, sd_cs, ch_ready); end
    total++; if (ch_rd[0 +: DW] !== 16'h0 || ch_rd_x[0 +: XW] !== 48'h0) begin bad++; $display("FAIL rstw_discard got=%0h/%0h exp=0", ch_rd[0 +: DW], ch_rd_x[0 +: XW]); end
  endtask

  task automatic test_ready_strobe_only();
    total++; if (bad_chg !== 0) begin bad++; $display("FAIL ready_off_strobe got=%0d exp=0", bad_chg); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_big_read();
    test_write();
    test_contention();
    test_ready_alignment();
    test_cs_drop();
    test_reset_wait();
    test_ready_strobe_only();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_multiport_front.md
Name: sdram_multiport_front

Overview:
- Parametrised successor to the single-port SRAM-like front end that sits ahead of sdram_ddr_controller.
- Accepts NUM_CH independent SRAM-like request channels from slow-logic masters, whose clock is derived from the UI clock. Arbitrates them round-robin onto the single controller port.
- Returns per-channel read data and a ready flag. Ready is re-timed to a slow-domain clock-enable strobe instead of edge-sampling a second clock.
- Runs entirely in the controller's UI clock domain.

Parameters:
- NUM_CH, 3, number of request channels (2..8).
- ADDR_W, 32, address width per channel.
- DATA_W, 16, primary data width; byte enables = DATA_W/8.
- EXTRA_W, 48, width of the additional big-read data.

Ports:
- clk  in  1  UI clock from the DDR3 controller; all logic on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_rtl_ce  in  1  one-cycle strobe marking each slow-logic rising edge.
- ch_addr  in  NUM_CH*ADDR_W  per-channel address; channel i at slice [i*ADDR_W +: ADDR_W].
- ch_cs  in  NUM_CH  per-channel chip select; held high until that channel's ready is seen.
- ch_we  in  NUM_CH  per-channel write enable.
- ch_be  in  NUM_CH*DATA_W/8  per-channel byte enables; bit0 = low byte.
- ch_wr  in  NUM_CH*DATA_W  per-channel write data.
- ch_big_r  in  NUM_CH  per-channel big-read request (ignored when we=1).
- ch_rd  out  NUM_CH*DATA_W  per-channel read data.
- ch_rd_x  out  NUM_CH*EXTRA_W  per-channel additional big-read data.
- ch_ready  out  NUM_CH  per-channel transaction ready.
- sd_addr  out  ADDR_W  to controller.
- sd_cs  out  1  to controller.
- sd_be  out  DATA_W/8  to controller.
- sd_we  out  1  to controller.
- sd_wr  out  DATA_W  to controller.
- sd_big_r  out  1  to controller.
- sd_rd  in  DATA_W  from controller; valid when sd_ready=1.
- sd_rd_x  in  EXTRA_W  from controller; valid when sd_ready=1.
- sd_ready  in  1  controller completion; high for at least 1 cycle.
- o_busy  out  1  high whenever state is not IDLE.
- o_grant  out  $clog2(NUM_CH)  index of the channel currently or last served.

Behaviour:
- Reset (synchronous): all outputs and registers go to 0. State=IDLE, rr pointer=NUM_CH-1, done=0, ch_ready=0, ch_rd/ch_rd_x=0.
- pending[i] = ch_cs[i] & ~done[i] & ~ch_ready[i].
- State machine: IDLE -> ISSUE -> WAIT -> DRAIN -> IDLE.
- IDLE: if any pending, grant g = first pending index after the rr pointer, wrapping modulo NUM_CH. Latch addr, be, we, wr and big_r of channel g into the sd_* registers. Set sd_cs=1 and rr pointer=g. Go to ISSUE on the next edge.
- ISSUE: one cycle with sd_cs held; go to WAIT.
- WAIT: sd_* held stable. When sd_ready=1:
  - capture sd_rd and sd_rd_x into channel g's read registers, only if we=0; write channels keep their previous read data;
  - set done[g]=1 and sd_cs=0;
  - go to DRAIN.
- DRAIN: one cycle with sd_cs=0, guaranteeing the controller sees the deassertion; then IDLE.
- Minimum back-to-back spacing: 4 UI cycles plus controller latency.
- Ready publication, evaluated only on i_rtl_ce=1, per channel:
  - if done[i]: ch_ready[i]<=1, done[i]<=0;
  - else if ch_ready[i] & ~ch_cs[i]: ch_ready[i]<=0.
  - Ready therefore rises and falls only at slow-clock edges and stays high while CS is held.
- A channel re-requests only after its ready has cleared, which makes it a full four-phase handshake.
- If done and i_rtl_ce coincide with that channel's sd_ready capture, publication waits for the next i_rtl_ce.
- Simultaneous requests: strict round-robin, no starvation. Each channel waits at most NUM_CH-1 transactions.
- ch_cs dropped mid-transaction (in ISSUE/WAIT): the transaction still completes and done is set. At the next i_rtl_ce ready pulses high; at the following i_rtl_ce it clears, since cs=0.
- sd_ready asserted while not in WAIT: ignored.
- Reset mid-transaction: state forced to IDLE and sd_cs=0 the next cycle. The in-flight result is discarded.
- Inputs are sampled only on the IDLE grant cycle; channel data changes afterwards have no effect.

Test Plan:
- Single read: ch1 cs=1, we=0, addr=0x100; controller returns sd_rd=0xBEEF after 5 cycles. Required: sd_addr=0x100, sd_cs high for 1+1+5 cycles, ch_rd[1]=0xBEEF. ch_ready[1] rises at the first i_rtl_ce after capture and clears at the i_rtl_ce after cs drops.
- Big read: ch0 big_r=1, sd_rd=0x1234, sd_rd_x=0xAABBCCDDEEFF. Required: ch_rd[0]=0x1234, ch_rd_x[0]=0xAABBCCDDEEFF, sd_big_r=1 during the transaction.
- Write with byte mask: ch2 we=1, be=2'b10, wr=0x5A00. Required: sd_we=1, sd_be=2'b10, sd_wr=0x5A00; ch_rd[2] unchanged from its prior value 0.
- Contention: all 3 channels request in the same cycle after reset. Required: grant order 0,1,2. Then ch0 and ch2 re-request with rr=2, giving order 0,2.
- Ready alignment: i_rtl_ce every 4 cycles, sd_ready arriving 1 cycle after a ce pulse. Required: ch_ready rises exactly at the next ce cycle, 3 cycles later, never between strobes.
- Reset during WAIT: assert i_rst for 1 cycle. Required: sd_cs=0 and o_busy=0 the next cycle, all ch_ready=0, and a late sd_ready pulse is ignored.
